// File: rtl/core_pkg.sv
// Shared pipeline control definitions: PC source encoding, hazard controller
// states and pipeline stage indices used by stall/clear vectors.
package core_pkg;

  localparam logic [3:0] PC_BOOT   = 4'd0;
  localparam logic [3:0] PC_JUMP   = 4'd2;
  localparam logic [3:0] PC_BRANCH = 4'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } ctrl_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forwarding select for one EX read port: picks the youngest stage
// writing the register being read, or 0 for the register file.
module fwd_select #(
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic [4:0]              raddr_i,
  input  logic                    rused_i,
  input  logic [NUM_FWD-1:0][4:0] waddr_i,
  input  logic [NUM_FWD-1:0]      we_i,
  output logic [SEL_W-1:0]        sel_o
);

  // Scan oldest to youngest so the lowest matching index wins.
  always_comb begin
    sel_o = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (we_i[k] && rused_i && (waddr_i[k] == raddr_i) && (waddr_i[k] != 5'd0)) begin
        sel_o = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use bubbles, data
// memory wait stalls, branch/jump redirects and stall/flush performance counters.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int NUM_RPORTS = 2,
  parameter int NUM_FWD    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(NUM_FWD + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            jump_decision_i,
  input  logic                            branch_decision_i,
  output logic                            pc_set_o,
  output logic [3:0]                      pc_mux_o,
  output logic [4:0]                      stall_o,
  output logic [4:0]                      clear_o,
  input  logic [NUM_RPORTS-1:0][4:0]      raddr_ex_i,
  input  logic [NUM_RPORTS-1:0]           rused_ex_i,
  input  logic [NUM_FWD-1:0][4:0]         waddr_i,
  input  logic [NUM_FWD-1:0]              we_i,
  input  logic                            load_mem_i,
  input  logic                            dmem_req_i,
  input  logic                            dmem_rvalid_i,
  output logic [NUM_RPORTS-1:0][SEL_W-1:0] fwd_sel_o,
  output logic [CNT_W-1:0]                stall_cnt_o,
  output logic [CNT_W-1:0]                flush_cnt_o,
  output ctrl_state_e                     state_o
);

  localparam logic [2:0] BUB_INIT = 3'(LOAD_LAT - 1);

  ctrl_state_e state_q, state_d;
  logic [2:0]  bub_q, bub_d;
  logic        load_use;
  logic        run_eval;
  logic [NUM_RPORTS-1:0][SEL_W-1:0] fwd_raw;

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_fwd
    fwd_select #(.NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_fwd_select (
      .raddr_i (raddr_ex_i[p]),
      .rused_i (rused_ex_i[p]),
      .waddr_i (waddr_i),
      .we_i    (we_i),
      .sel_o   (fwd_raw[p])
    );
  end

  assign fwd_sel_o = rst ? '0 : fwd_raw;
  assign state_o   = state_q;

  always_comb begin
    load_use = 1'b0;
    if (load_mem_i && we_i[0] && (waddr_i[0] != 5'd0)) begin
      for (int p = 0; p < NUM_RPORTS; p++) begin
        if (rused_ex_i[p] && (raddr_ex_i[p] == waddr_i[0])) load_use = 1'b1;
      end
    end
  end

  // Handshake: a data request completes in the cycle dmem_rvalid_i is high;
  // any cycle with dmem_req_i high and dmem_rvalid_i low holds IF..MEM.
  always_comb begin
    state_d  = state_q;
    bub_d    = bub_q;
    stall_o  = '0;
    clear_o  = '0;
    pc_set_o = 1'b0;
    pc_mux_o = PC_BOOT;
    run_eval = 1'b0;

    case (state_q)
      RUN: run_eval = 1'b1;
      LU_STALL: begin
        if (bub_q != 3'd0) begin
          stall_o[STG_IF]  = 1'b1;
          stall_o[STG_ID]  = 1'b1;
          stall_o[STG_EX]  = 1'b1;
          clear_o[STG_MEM] = 1'b1;
          bub_d            = bub_q - 3'd1;
        end else begin
          state_d  = RUN;
          run_eval = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_rvalid_i) begin
          state_d  = RUN;
          run_eval = 1'b1;
        end else begin
          stall_o[STG_MEM:STG_IF] = 4'hF;
          clear_o[STG_WB]         = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Redirects only act when nothing is stalled; a held resolver re-resolves.
    if (run_eval) begin
      if (dmem_req_i && !dmem_rvalid_i) begin
        stall_o[STG_MEM:STG_IF] = 4'hF;
        clear_o[STG_WB]         = 1'b1;
        state_d                 = MEM_WAIT;
      end else if (load_use) begin
        stall_o[STG_IF]  = 1'b1;
        stall_o[STG_ID]  = 1'b1;
        stall_o[STG_EX]  = 1'b1;
        clear_o[STG_MEM] = 1'b1;
        bub_d            = BUB_INIT;
        state_d          = (BUB_INIT == 3'd0) ? RUN : LU_STALL;
      end else if (branch_decision_i) begin
        pc_set_o        = 1'b1;
        pc_mux_o        = PC_BRANCH;
        clear_o[STG_ID] = 1'b1;
        clear_o[STG_EX] = 1'b1;
      end else if (jump_decision_i) begin
        pc_set_o        = 1'b1;
        pc_mux_o        = PC_JUMP;
        clear_o[STG_ID] = 1'b1;
      end
    end

    if (rst) begin
      stall_o  = '0;
      clear_o  = '0;
      pc_set_o = 1'b0;
      pc_mux_o = PC_BOOT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      bub_q       <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      state_q <= state_d;
      bub_q   <= bub_d;
      if ((|stall_o) && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (pc_set_o && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end

endmodule
